alu_pipe: RTL and testbench

Parametrised, two-stage pipelined integer ALU. It generalises the team's 4-bit signed adder to any width and eight operations, and reports zero, negative, carry and signed-overflow flags. It adds a valid/ready handshake on both sides and a sticky overflow status bit. It sits between an operand source, such as a decode or register-read stage, and a result consumer that may apply backpressure.

---
 rtl/alu_pipe.sv | 139 +++++++++++++
 tb/tb_alu_pipe.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Two-stage pipelined integer ALU with valid/ready handshakes on both sides,
// ZNCV flags and a sticky signed-overflow status bit.
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             ovf_sticky,
  input  logic             clr_sticky
);

  localparam int MSB = WIDTH - 1;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_NOT = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_SLT = 3'b110,
    OP_EQ  = 3'b111
  } op_e;

  // Stage 1 state
  logic             s1_valid_q, s1_valid_d;
  logic [2:0]       s1_op_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;

  // Stage 2 state (drives the outputs directly)
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] res_q;
  logic             zero_q, neg_q, carry_q, ovf_q;
  logic             sticky_q, sticky_d;

  logic s2_adv, s1_adv, accept, s2_load;

  // Combinational ready chain from the consumer back to the source.
  assign s2_adv  = !s2_valid_q || out_ready;
  assign s1_adv  = !s1_valid_q || s2_adv;
  assign accept  = in_valid && s1_adv;
  assign s2_load = s2_adv && s1_valid_q;

  assign s1_valid_d = accept || (s1_valid_q && !s2_adv);
  assign s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;

  // Set takes priority over a simultaneous clear.
  assign sticky_d = (s2_valid_q && out_ready && ovf_q) ? 1'b1 :
                    (clr_sticky ? 1'b0 : sticky_q);

  // Execute on the registered stage-1 operands.
  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res_c;
  logic             carry_c, ovf_c, zero_c, neg_c;

  assign is_sub = (s1_op_q == OP_SUB);
  assign b_eff  = is_sub ? ~s1_b_q : s1_b_q;
  assign sum    = {1'b0, s1_a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};

  always_comb begin
    res_c   = '0;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    unique case (op_e'(s1_op_q))
      OP_ADD, OP_SUB: begin
        res_c   = sum[MSB:0];
        carry_c = sum[WIDTH];
        ovf_c   = (s1_a_q[MSB] == b_eff[MSB]) && (sum[MSB] != s1_a_q[MSB]);
      end
      OP_NOT: res_c = ~s1_a_q;
      OP_AND: res_c = s1_a_q & s1_b_q;
      OP_OR:  res_c = s1_a_q | s1_b_q;
      OP_XOR: res_c = s1_a_q ^ s1_b_q;
      // Direct signed compare, so SLT stays correct when a-b overflows.
      OP_SLT: res_c = {{(WIDTH-1){1'b0}}, ($signed(s1_a_q) < $signed(s1_b_q))};
      OP_EQ:  res_c = {{(WIDTH-1){1'b0}}, (s1_a_q == s1_b_q)};
      default: res_c = '0;
    endcase
  end

  assign zero_c = (res_c == '0);
  assign neg_c  = res_c[MSB];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      zero_q     <= 1'b0;
      neg_q      <= 1'b0;
      carry_q    <= 1'b0;
      ovf_q      <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      sticky_q   <= sticky_d;
      if (accept) begin
        s1_op_q <= op;
        s1_a_q  <= a;
        s1_b_q  <= b;
      end
      if (s2_load) begin
        res_q   <= res_c;
        zero_q  <= zero_c;
        neg_q   <= neg_c;
        carry_q <= carry_c;
        ovf_q   <= ovf_c;
      end
    end
  end

  assign in_ready   = s1_adv;
  assign out_valid  = s2_valid_q;
  assign result     = res_q;
  assign zero       = zero_q;
  assign negative   = neg_q;
  assign carry      = carry_q;
  assign overflow   = ovf_q;
  assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe at WIDTH=8: the driver queues hand-computed
// expectations on acceptance, the monitor checks each delivered result.
module tb_alu_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         zero, negative, carry, overflow, ovf_sticky;
  logic         clr_sticky = 1'b0;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .negative(negative),
    .carry(carry), .overflow(overflow),
    .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] r;
    logic z, n, c, v;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   txn      = 0;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, NOT_ = 3'd2, AND_ = 3'd3,
                         OR_ = 3'd4, XOR_ = 3'd5, SLT = 3'd6, EQ = 3'd7;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] r, input logic z, n, c, v);
    exp_t e;
    e.r = r; e.z = z; e.n = n; e.c = c; e.v = v;
    return e;
  endfunction

  // Presents one op (entered just after a rising edge), waits for acceptance,
  // queues its expectation, and returns #1 after the accepting edge.
  task automatic send(input logic [2:0] o, input logic [W-1:0] va, vb, input exp_t e);
    int n;
    in_valid = 1'b1; op = o; a = va; b = vb;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL send_timeout: in_ready stayed 0 for op %0d", o);
    end else begin
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Waits (bounded) at falling edges until out_valid equals lvl.
  task automatic wait_valid(input logic lvl, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (out_valid !== lvl && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk(name, {31'd0, out_valid}, {31'd0, lvl});
  endtask

  // Monitor: compare every handshake against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_output: got result %h with nothing queued", result);
        end else begin
          e = exp_q.pop_front();
          txn++;
          $display("txn %0d result=%h z=%b n=%b c=%b v=%b", txn, result, zero, negative, carry, overflow);
          chk("txn_result_flags", {20'd0, result, zero, negative, carry, overflow},
              {20'd0, e.r, e.z, e.n, e.c, e.v});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_result", {24'd0, result}, 32'd0);
    chk("reset_flags", {27'd0, zero, negative, carry, overflow, ovf_sticky}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

    // Directed vectors, back to back with no backpressure
    out_ready = 1'b1;
    send(ADD,  8'h7F, 8'h01, mk(8'h80, 0, 1, 0, 1));
    send(SUB,  8'h00, 8'h01, mk(8'hFF, 0, 1, 0, 0));
    send(SUB,  8'h80, 8'h01, mk(8'h7F, 0, 0, 1, 1));
    send(ADD,  8'hFF, 8'h01, mk(8'h00, 1, 0, 1, 0));
    send(SLT,  8'h80, 8'h01, mk(8'h01, 0, 0, 0, 0));
    send(EQ,   8'h5A, 8'h5A, mk(8'h01, 0, 0, 0, 0));
    send(XOR_, 8'h5A, 8'h5A, mk(8'h00, 1, 0, 0, 0));
    send(NOT_, 8'h0F, 8'h00, mk(8'hF0, 0, 1, 0, 0));
    send(AND_, 8'hF0, 8'h3C, mk(8'h30, 0, 0, 0, 0));
    send(OR_,  8'hF0, 8'h0C, mk(8'hFC, 0, 1, 0, 0));
    send(SLT,  8'h01, 8'h80, mk(8'h00, 1, 0, 0, 0));
    send(EQ,   8'h5A, 8'h5B, mk(8'h00, 1, 0, 0, 0));
    send(SUB,  8'h05, 8'h05, mk(8'h00, 1, 0, 1, 0));
    wait_valid(1'b0, "drain_directed");
    chk("sticky_after_overflow", {31'd0, ovf_sticky}, 32'd1);

    // Plain clear
    @(posedge clk); #1;
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    chk("sticky_cleared", {31'd0, ovf_sticky}, 32'd0);

    // Set and clear in the same cycle: set wins, then clear takes effect
    clr_sticky = 1'b1;
    send(ADD, 8'h7F, 8'h01, mk(8'h80, 0, 1, 0, 1));
    wait_valid(1'b1, "sticky_op_valid");
    @(posedge clk); #1;
    chk("sticky_set_wins", {31'd0, ovf_sticky}, 32'd1);
    @(posedge clk); #1;
    chk("sticky_clear_next", {31'd0, ovf_sticky}, 32'd0);
    clr_sticky = 1'b0;

    // Backpressure: pipe fills two deep, third op waits
    out_ready = 1'b0;
    in_valid = 1'b1; op = ADD; a = 8'h01; b = 8'h02;
    @(negedge clk);
    chk("bp_ready_1", {31'd0, in_ready}, 32'd1);
    exp_q.push_back(mk(8'h03, 0, 0, 0, 0));
    @(posedge clk); #1;
    a = 8'h03; b = 8'h04;
    @(negedge clk);
    chk("bp_ready_2", {31'd0, in_ready}, 32'd1);
    exp_q.push_back(mk(8'h07, 0, 0, 0, 0));
    @(posedge clk); #1;
    a = 8'h05; b = 8'h06;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_ready_3_low", {31'd0, in_ready}, 32'd0);
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_result", {24'd0, result}, 32'h03);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_rises", {31'd0, in_ready}, 32'd1);
    exp_q.push_back(mk(8'h0B, 0, 0, 0, 0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("bp_stream_valid", {31'd0, out_valid}, 32'd1);
    end
    @(negedge clk);
    chk("bp_stream_end", {31'd0, out_valid}, 32'd0);
    chk("bp_all_delivered", exp_q.size(), 32'd0);

    // Asynchronous reset with two ops in flight
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(ADD, 8'h10, 8'h20, mk(8'h30, 0, 0, 0, 0));
    send(ADD, 8'h01, 8'h01, mk(8'h02, 0, 0, 0, 0));
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_result", {24'd0, result}, 32'd0);
    chk("arst_flags", {27'd0, zero, negative, carry, overflow, ovf_sticky}, 32'd0);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    send(ADD, 8'h22, 8'h11, mk(8'h33, 0, 0, 0, 0));
    chk("latency_not_early", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("latency_valid", {31'd0, out_valid}, 32'd1);
    chk("latency_result", {24'd0, result}, 32'h33);
    wait_valid(1'b0, "drain_final");
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
